// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes the release of the pin reset, stretches it,
// then releases a set of active-low reset outputs one at a time in order.
// Also restarts the stretch/release sequence on a software request in RUN,
// records the cause of the last reset and counts software resets.
module reset_sequencer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned NUM_OUTS       = 3,
    parameter int unsigned STEP_CYCLES    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sw_rst_req,
    output logic [NUM_OUTS-1:0] rst_out_n,
    output logic                ready,
    output logic [1:0]          rst_cause,
    output logic [7:0]          sw_rst_cnt
);

    localparam int unsigned CNT_MAX = (STRETCH_CYCLES > STEP_CYCLES) ? STRETCH_CYCLES : STEP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] CAUSE_PIN = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    typedef enum logic [1:0] {
        SYNC,
        STRETCH,
        RELEASE,
        RUN
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic [NUM_OUTS-1:0]    out_next;
    logic                   ready_next;
    logic [1:0]             cause_next;
    logic [7:0]             sw_cnt_next;

    // Release synchronizer: async clear, shifts in ones once rst is released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

    // State, counter and all registered outputs; async clear to reset values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SYNC;
            cnt        <= '0;
            rst_out_n  <= '0;
            ready      <= 1'b0;
            rst_cause  <= CAUSE_PIN;
            sw_rst_cnt <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            rst_out_n  <= out_next;
            ready      <= ready_next;
            rst_cause  <= cause_next;
            sw_rst_cnt <= sw_cnt_next;
        end
    end

    // Next-state and next-output logic for the sequencing FSM
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        out_next    = rst_out_n;
        cause_next  = rst_cause;
        sw_cnt_next = sw_rst_cnt;

        case (state)
            SYNC: begin
                // Leave on the same edge that rst_sync rises (the stage before
                // it is already high), so the stretch starts counting from there.
                if (rst_sync || sync_q[SYNC_STAGES-2]) begin
                    state_next = STRETCH;
                    cnt_next   = '0;
                end
            end

            STRETCH: begin
                if (cnt == CNT_W'(STRETCH_CYCLES - 1)) begin
                    state_next = RELEASE;
                    cnt_next   = '0;
                    out_next   = NUM_OUTS'(1);
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            RELEASE: begin
                if (&rst_out_n) begin
                    state_next = RUN;
                end else if (cnt == CNT_W'(STEP_CYCLES - 1)) begin
                    cnt_next = '0;
                    out_next = (rst_out_n << 1) | NUM_OUTS'(1);
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            RUN: begin
                if (sw_rst_req) begin
                    state_next = STRETCH;
                    cnt_next   = '0;
                    out_next   = '0;
                    cause_next = CAUSE_SW;
                    if (sw_rst_cnt != 8'hFF) begin
                        sw_cnt_next = sw_rst_cnt + 8'd1;
                    end
                end
            end

            default: begin
                state_next = SYNC;
                cnt_next   = '0;
                out_next   = '0;
            end
        endcase

        ready_next = (state_next == RUN);
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with default parameters.
// Reference model: outputs derived from the edge count since the last
// reset origin (pin release or accepted software request).
module tb_reset_sequencer;

    localparam int SS = 2;
    localparam int SC = 16;
    localparam int NO = 3;
    localparam int SP = 4;
    localparam int VW = NO + 11;

    logic          clk        = 1'b0;
    logic          clk_en     = 1'b1;
    logic          rst        = 1'b1;
    logic          sw_rst_req = 1'b0;
    logic [NO-1:0] rst_out_n;
    logic          ready;
    logic [1:0]    rst_cause;
    logic [7:0]    sw_rst_cnt;
    logic [VW-1:0] obs;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model state
    int         n;        // clk edges since rst release (E-number of last edge)
    int         x;        // origin edge of the current stretch/release sequence
    logic [1:0] m_cause;
    int         m_cnt;

    reset_sequencer #(
        .SYNC_STAGES   (SS),
        .STRETCH_CYCLES(SC),
        .NUM_OUTS      (NO),
        .STEP_CYCLES   (SP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_rst_req(sw_rst_req),
        .rst_out_n (rst_out_n),
        .ready     (ready),
        .rst_cause (rst_cause),
        .sw_rst_cnt(sw_rst_cnt)
    );

    assign obs = {rst_out_n, ready, rst_cause, sw_rst_cnt};

    always #5 if (clk_en) clk = ~clk;

    function automatic logic [NO-1:0] exp_out();
        logic [NO-1:0] v;
        for (int i = 0; i < NO; i++) v[i] = (n >= x + SC + i * SP);
        return v;
    endfunction

    function automatic logic exp_ready();
        return (n >= x + SC + (NO - 1) * SP + 1);
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {exp_out(), exp_ready(), m_cause, 8'(m_cnt)};
    endfunction

    task automatic model_reset();
        n       = 0;
        x       = SS;
        m_cause = 2'b01;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        logic in_run;
        in_run = exp_ready();
        n++;
        if (in_run && sw_rst_req) begin
            x       = n;
            m_cause = 2'b10;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
    endtask

    task automatic do_pin_reset();
        sw_rst_req = 1'b0;
        rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_immediate got=%b exp=%b", obs, exp_vec());
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL reset_held cyc=%0d got=%b exp=%b", c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_power_on();
        logic [2:0] c_out;
        rst = 1'b1;
        for (int c = 0; c < 32; c++) begin
            tick();
            c_out = (n >= 26) ? 3'b111 : (n >= 22) ? 3'b011 : (n >= 18) ? 3'b001 : 3'b000;
            checks++;
            if (obs !== exp_vec() || rst_out_n !== c_out || ready !== (n >= 27)) begin
                errors++;
                $display("FAIL power_on E%0d got=%b exp=%b out_req=%b", n, obs, exp_vec(), c_out);
            end
        end
    endtask

    task automatic test_glitch();
        int at;
        int w;
        for (int g = 0; g < 4; g++) begin
            do_pin_reset();
            at = (g == 0) ? 20 : int'($urandom_range(1, 30));
            w  = (g == 0) ? 3 : int'($urandom_range(1, 4));
            while (n < at) begin
                tick();
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL glitch_pre E%0d got=%b exp=%b", n, obs, exp_vec());
                end
            end
            rst = 1'b0;
            model_reset();
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL glitch_async at=E%0d got=%b exp=%b", at, obs, exp_vec());
            end
            #(w - 1);
            rst = 1'b1;
            for (int c = 0; c < 30; c++) begin
                tick();
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL glitch_post E%0d got=%b exp=%b", n, obs, exp_vec());
                end
            end
        end
    endtask

    task automatic test_sw_reset();
        int len;
        int base;
        do_pin_reset();
        for (int r = 0; r < 8; r++) begin
            for (int t = 0; t < 40 && !exp_ready(); t++) begin
                tick();
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL sw_wait E%0d got=%b exp=%b", n, obs, exp_vec());
                end
            end
            repeat ($urandom_range(0, 5)) tick();
            len  = (r == 0) ? 1 : int'($urandom_range(1, 4));
            base = m_cnt;
            sw_rst_req = 1'b1;
            for (int c = 0; c < len; c++) begin
                tick();
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL sw_pulse E%0d got=%b exp=%b", n, obs, exp_vec());
                end
            end
            sw_rst_req = 1'b0;
            checks++;
            if (sw_rst_cnt !== 8'(base + 1) || rst_cause !== 2'b10 || rst_out_n !== '0) begin
                errors++;
                $display("FAIL sw_once cnt=%0d cause=%b out=%b req_cnt=%0d", sw_rst_cnt, rst_cause, rst_out_n, base + 1);
            end
            for (int c = 0; c < 28; c++) begin
                tick();
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL sw_seq E%0d got=%b exp=%b", n, obs, exp_vec());
                end
            end
        end
    endtask

    task automatic test_ignored();
        for (int r = 0; r < 3; r++) begin
            do_pin_reset();
            for (int c = 0; c < 34; c++) begin
                if (n < 27) sw_rst_req = (r == 0) ? (n >= 2) : 1'($urandom);
                else sw_rst_req = 1'b0;
                tick();
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL ignored E%0d got=%b exp=%b", n, obs, exp_vec());
                end
            end
            checks++;
            if (sw_rst_cnt !== 8'd0 || rst_cause !== 2'b01 || ready !== 1'b1) begin
                errors++;
                $display("FAIL ignored_final cnt=%0d cause=%b ready=%b", sw_rst_cnt, rst_cause, ready);
            end
        end
        sw_rst_req = 1'b0;
    endtask

    task automatic test_saturation();
        do_pin_reset();
        for (int r = 0; r < 261; r++) begin
            for (int t = 0; t < 40 && !exp_ready(); t++) begin
                tick();
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL sat_run E%0d got=%b exp=%b", n, obs, exp_vec());
                end
            end
            if (r < 260) begin
                sw_rst_req = 1'b1;
                tick();
                sw_rst_req = 1'b0;
            end
        end
        checks++;
        if (sw_rst_cnt !== 8'd255 || ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_count got=%0d ready=%b exp=255", sw_rst_cnt, ready);
        end
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (sw_rst_cnt !== 8'd0 || rst_cause !== 2'b01 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL sat_clear cnt=%0d cause=%b exp cnt=0 cause=01", sw_rst_cnt, rst_cause);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_clockless();
        for (int t = 0; t < 40 && !exp_ready(); t++) tick();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        for (int t = 0; t < 40 && !exp_ready(); t++) tick();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL clockless_pre got=%b exp=%b", obs, exp_vec());
        end
        clk_en = 1'b0;
        #23;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (rst_out_n !== '0 || ready !== 1'b0 || rst_cause !== 2'b01 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL clockless_assert got=%b exp=%b", obs, exp_vec());
        end
        #30;
        rst = 1'b1;
        #7;
        clk_en = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL clockless_restart E%0d got=%b exp=%b", n, obs, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_power_on();
        test_glitch();
        test_sw_reset();
        test_ignored();
        test_saturation();
        test_clockless();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
